// File: rtl/seg_scan_display_n.sv
// seg_scan_display_n
//   Multiplexed common-anode 7-segment display controller.
//   It scans DIGITS digits and shows {press_count, switch} as hex.
//   A debounced push-button increments a wrapping press counter.
//   Each digit can be disabled through a mask.
//   Leading zeros can be blanked, and each digit has a decimal point.
//
// Ports
//   clk       system clock
//   clr       synchronous active-high reset
//   button    raw push-button (asynchronous, bouncy)
//   switch    value shown in the low SW_W/4 digits
//   en_mask   per-digit enable (1 = digit may light)
//   dp_mask   per-digit decimal point (1 = dp lit)
//   lz_blank  1 = blank leading zero digits (digit 0 is never blanked)
//   led_en    digit enables, active-low, one-hot
//   led_cx    segments {a,b,c,d,e,f,g,dp}, active-low
module seg_scan_display_n #(
    parameter int DIGITS       = 8,
    parameter int SW_W         = 8,
    parameter int SCAN_DIV     = 200000,
    parameter int DEBOUNCE_CYC = 1500000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              button,
    input  logic [SW_W-1:0]   switch,
    input  logic [DIGITS-1:0] en_mask,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic              lz_blank,
    output logic [DIGITS-1:0] led_en,
    output logic [7:0]        led_cx
);

    localparam int DW    = DIGITS * 4;
    localparam int CW    = DW - SW_W;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic              sync1_reg, sync2_reg;
    logic              deb_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic [CW-1:0]     count_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DIGITS-1:0] led_en_reg, led_en_next;
    logic [7:0]        led_cx_reg, led_cx_next;

    logic [DW-1:0]     disp;
    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] upper_zero;
    logic [3:0]        nibble;
    logic              blank;

    // Active-low {a,b,c,d,e,f,g} glyphs for the standard hex font.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    // Button path: a 2-flop synchroniser, then a stability counter.
    // The counter runs only while the synced level differs from the
    // debounced level. Any bounce back clears it, so only a level held
    // for DEBOUNCE_CYC cycles is accepted. The synchroniser is also
    // cleared, so a button held through clr is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            deb_reg    <= 1'b0;
            db_cnt_reg <= '0;
            count_reg  <= '0;
        end else begin
            sync1_reg <= button;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
                deb_reg    <= ~deb_reg;
                db_cnt_reg <= '0;
                // Count only the rising edge of the debounced level.
                if (!deb_reg)
                    count_reg <= count_reg + 1'b1;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            div_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign disp = {count_reg, switch};

    // For each slot: its nibble, and whether it and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = disp[4*gi +: 4];
            assign upper_zero[gi] = (disp[DW-1:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        nibble      = nib[idx_reg];
        blank       = ~en_mask[idx_reg] |
                      (lz_blank & (idx_reg != '0) & upper_zero[idx_reg]);
        led_en_next = ~(DIGITS'(1) << idx_reg);
        led_cx_next = {glyph(nibble), ~dp_mask[idx_reg]};
        if (blank) begin
            led_en_next = '1;
            led_cx_next = 8'hFF;
        end
    end

    // Registered outputs give glitch-free pins. Asynchronous switch and
    // mask changes are picked up on the next clock.
    always_ff @(posedge clk) begin
        if (clr) begin
            led_en_reg <= '1;
            led_cx_reg <= 8'hFF;
        end else begin
            led_en_reg <= led_en_next;
            led_cx_reg <= led_cx_next;
        end
    end

    assign led_en = led_en_reg;
    assign led_cx = led_cx_reg;

endmodule

// File: tb/tb_seg_scan_display_n.sv
// Directed bench for seg_scan_display_n.
// Parameters: DIGITS=4, SW_W=8, SCAN_DIV=4, DEBOUNCE_CYC=8.
// The press count (CW=8) is read back through the glyphs on digits 2 and 3.
module tb_seg_scan_display_n;

    logic       clk = 1'b0;
    logic       clr;
    logic       button;
    logic [7:0] switch;
    logic [3:0] en_mask;
    logic [3:0] dp_mask;
    logic       lz_blank;
    logic [3:0] led_en;
    logic [7:0] led_cx;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_display_n #(
        .DIGITS(4), .SW_W(8), .SCAN_DIV(4), .DEBOUNCE_CYC(8)
    ) dut (
        .clk(clk), .clr(clr), .button(button), .switch(switch),
        .en_mask(en_mask), .dp_mask(dp_mask), .lz_blank(lz_blank),
        .led_en(led_en), .led_cx(led_cx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Advance to the first cycle of a digit-0 slot (bounded).
    task automatic sync_slot0(input string tag);
        logic [3:0] prev;
        bit         found;
        prev  = led_en;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (led_en == 4'b1110 && prev != 4'b1110)
                found = 1'b1;
            prev = led_en;
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL %s_sync: observed led_en %b, required 1110 within 40 cycles", tag, led_en);
        end
    endtask

    // Check slot k at its second cycle, measured from a digit-0 slot start.
    task automatic check_at(input int k, input logic [3:0] en, input logic [7:0] cx,
                            input string tag);
        sync_slot0(tag);
        repeat (4 * k + 1) tick();
        chk({tag, "_en"}, {4'h0, led_en}, {4'h0, en});
        chk({tag, "_cx"}, led_cx, cx);
    endtask

    task automatic press();
        button = 1'b1;
        repeat (12) tick();
        button = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cx_tab [4];
        logic [3:0] exp_en;

        clr = 1'b1; button = 1'b0; switch = 8'h66;
        en_mask = 4'hF; dp_mask = 4'h0; lz_blank = 1'b0;

        // 1/2: reset state, then the scan order with the '6','6','0','0' display.
        repeat (5) tick();
        chk("rst_en", {4'h0, led_en}, 8'h0F);
        chk("rst_cx", led_cx, 8'hFF);
        clr = 1'b0;
        cx_tab[0] = 8'h41; cx_tab[1] = 8'h41; cx_tab[2] = 8'h03; cx_tab[3] = 8'h03;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_en = ~(4'b0001 << ((c / 4) % 4));
            chk($sformatf("scan%0d_en", c), {4'h0, led_en}, {4'h0, exp_en});
            chk($sformatf("scan%0d_cx", c), led_cx, cx_tab[(c / 4) % 4]);
        end

        // 3: short bounces are ignored; one long hold counts exactly once.
        for (int p = 0; p < 3; p++) begin
            button = 1'b1; tick();
            button = 1'b0; tick(); tick();
        end
        button = 1'b1; repeat (20) tick();
        button = 1'b0; repeat (20) tick();
        check_at(2, 4'b1011, 8'h9F, "cnt1_d2");
        check_at(3, 4'b0111, 8'h03, "cnt1_d3");

        // 4: 254 more presses reach 0xFF; one more wraps the count to 0x00.
        repeat (254) press();
        check_at(2, 4'b1011, 8'h71, "cntFF_d2");
        check_at(3, 4'b0111, 8'h71, "cntFF_d3");
        press();
        check_at(2, 4'b1011, 8'h03, "wrap_d2");
        check_at(3, 4'b0111, 8'h03, "wrap_d3");

        // 5: leading-zero blanking and the decimal point.
        lz_blank = 1'b1; switch = 8'h05;
        check_at(0, 4'b1110, 8'h49, "lz05_d0");
        check_at(1, 4'b1111, 8'hFF, "lz05_d1");
        check_at(2, 4'b1111, 8'hFF, "lz05_d2");
        check_at(3, 4'b1111, 8'hFF, "lz05_d3");
        dp_mask = 4'b0001;
        check_at(0, 4'b1110, 8'h48, "dp_d0");
        // Digit 0 stays lit even when it is zero.
        dp_mask = 4'b0000; switch = 8'h50;
        check_at(0, 4'b1110, 8'h03, "lz50_d0");
        check_at(1, 4'b1101, 8'h49, "lz50_d1");
        check_at(2, 4'b1111, 8'hFF, "lz50_d2");

        // Enable mask blanks a single slot.
        lz_blank = 1'b0; switch = 8'h66; en_mask = 4'b1101;
        check_at(0, 4'b1110, 8'h41, "mask_d0");
        check_at(1, 4'b1111, 8'hFF, "mask_d1");
        check_at(2, 4'b1011, 8'h03, "mask_d2");
        en_mask = 4'hF;

        // 6: reach count 3 with the button held, then clr mid-operation.
        press(); press();
        button = 1'b1;
        repeat (14) tick();
        check_at(2, 4'b1011, 8'h0D, "cnt3_d2");
        check_at(3, 4'b0111, 8'h03, "cnt3_d3");
        clr = 1'b1;
        tick();
        chk("clr_en", {4'h0, led_en}, 8'h0F);
        chk("clr_cx", led_cx, 8'hFF);
        clr = 1'b0;
        tick();
        chk("post_clr_en", {4'h0, led_en}, 8'h0E);
        chk("post_clr_cx", led_cx, 8'h41);
        repeat (24) tick();
        chk("reheld_d2_en", {4'h0, led_en}, 8'h0B);
        chk("reheld_d2_cx", led_cx, 8'h9F);
        repeat (4) tick();
        chk("reheld_d3_en", {4'h0, led_en}, 8'h07);
        chk("reheld_d3_cx", led_cx, 8'h03);
        button = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
